// File: rtl/mem_block_mover.sv
// Block copy/fill engine that borrows the data memory port from the CPU.
// Copies read one word then write it; fills write one word per cycle.
module mem_block_mover #(
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               fill_mode,
    input  logic [7:0]         src_base,
    input  logic [7:0]         dst_base,
    input  logic [7:0]         length,
    input  logic [D_WIDTH-1:0] fill_value,
    input  logic               cpu_mem_write,
    input  logic [7:0]         cpu_addr,
    input  logic [D_WIDTH-1:0] cpu_write_data,
    output logic [D_WIDTH-1:0] cpu_read_data,
    output logic               mem_write,
    output logic [7:0]         mem_addr,
    output logic [D_WIDTH-1:0] mem_write_data,
    input  logic [D_WIDTH-1:0] mem_read_data,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state
);

    // Handshake: start is a one-shot request honoured only in IDLE (never
    // queued); operands are captured with it. done pulses for exactly one
    // cycle when the block finishes. There is no backpressure.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [7:0]         i_r;
    logic [7:0]         src_r;
    logic [7:0]         dst_r;
    logic [7:0]         len_r;
    logic [D_WIDTH-1:0] fill_r;
    logic               mode_r;
    logic [D_WIDTH-1:0] buf_r;
    logic [7:0]         i_next;

    assign i_next = i_r + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            i_r    <= '0;
            src_r  <= '0;
            dst_r  <= '0;
            len_r  <= '0;
            fill_r <= '0;
            mode_r <= 1'b0;
            buf_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_r  <= src_base;
                        dst_r  <= dst_base;
                        len_r  <= length;
                        fill_r <= fill_value;
                        mode_r <= fill_mode;
                        i_r    <= '0;
                        if (length == 8'd0) begin
                            state <= DONE;
                        end else if (fill_mode) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    buf_r <= mem_read_data;
                    state <= WR;
                end
                WR: begin
                    i_r <= i_next;
                    if (i_next == len_r) begin
                        state <= DONE;
                    end else if (mode_r) begin
                        state <= WR;
                    end else begin
                        state <= RD;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outside RD/WR the CPU owns the memory port through a plain passthrough.
    always_comb begin
        mem_write      = cpu_mem_write;
        mem_addr       = cpu_addr;
        mem_write_data = cpu_write_data;
        case (state)
            RD: begin
                mem_write      = 1'b0;
                mem_addr       = src_r + i_r;
                mem_write_data = buf_r;
            end
            WR: begin
                mem_write      = 1'b1;
                mem_addr       = dst_r + i_r;
                mem_write_data = mode_r ? fill_r : buf_r;
            end
            default: begin
            end
        endcase
    end

    assign cpu_read_data = mem_read_data;
    assign busy          = (state == RD) || (state == WR);
    assign done          = (state == DONE);
    assign dbg_state     = state;

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: behavioural memory, array-level reference model
// and an expected-write queue checked against every observed memory write.
module tb_mem_block_mover;

    localparam int DW = 8;

    logic          clk;
    logic          reset;
    logic          start;
    logic          fill_mode;
    logic [7:0]    src_base;
    logic [7:0]    dst_base;
    logic [7:0]    length;
    logic [DW-1:0] fill_value;
    logic          cpu_mem_write;
    logic [7:0]    cpu_addr;
    logic [DW-1:0] cpu_write_data;
    logic [DW-1:0] cpu_read_data;
    logic          mem_write;
    logic [7:0]    mem_addr;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    logic [15:0]   exp_q[$];

    mem_block_mover #(.D_WIDTH(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .fill_mode      (fill_mode),
        .src_base       (src_base),
        .dst_base       (dst_base),
        .length         (length),
        .fill_value     (fill_value),
        .cpu_mem_write  (cpu_mem_write),
        .cpu_addr       (cpu_addr),
        .cpu_write_data (cpu_write_data),
        .cpu_read_data  (cpu_read_data),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .busy           (busy),
        .done           (done),
        .dbg_state      (dbg_state)
    );

    // clock / reset and the data memory the DUT drives
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_write_data;
    end

    // Reference model: word k of the block lands at dst+k in ascending order,
    // taking fill_value or the current (already updated) source word.
    task automatic model_op(input logic fm, input logic [7:0] src, input logic [7:0] dst,
                            input int n, input logic [DW-1:0] val);
        for (int k = 0; k < n; k++) begin
            logic [7:0]    a;
            logic [7:0]    s;
            logic [DW-1:0] d;
            a = dst + k[7:0];
            s = src + k[7:0];
            d = fm ? val : ref_mem[s];
            ref_mem[a] = d;
            exp_q.push_back({a, d});
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        cpu_mem_write  = 1'b1;
        cpu_addr       = a;
        cpu_write_data = d;
        @(negedge clk);
        cpu_mem_write  = 1'b0;
        ref_mem[a]     = d;
    endtask

    task automatic compare_mem(input string name);
        int bad = 0;
        int first = 0;
        for (int a = 0; a < 256; a++) begin
            if (mem[a] !== ref_mem[a]) begin
                if (bad == 0) first = a;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s mem: %0d words differ, first at 0x%02h got 0x%02h want 0x%02h",
                     name, bad, first, mem[first], ref_mem[first]);
        end
    endtask

    // Drives one operation and checks every write, busy count, done timing.
    task automatic run_op(input logic fm, input logic [7:0] src, input logic [7:0] dst,
                          input logic [7:0] len, input logic [DW-1:0] val,
                          input bit cpu_during, input bit hold_start, input string name);
        int busy_cyc = 0;
        int done_cnt = 0;
        int done_at  = 0;
        int exp_busy;
        logic [15:0] e;
        exp_busy = fm ? int'(len) : 2 * int'(len);
        model_op(fm, src, dst, int'(len), val);
        @(negedge clk);
        start      = 1'b1;
        fill_mode  = fm;
        src_base   = src;
        dst_base   = dst;
        length     = len;
        fill_value = val;
        for (int c = 1; c <= 700; c++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            if (busy) busy_cyc++;
            if (mem_write) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s write: unexpected write addr 0x%02h data 0x%02h",
                             name, mem_addr, mem_write_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_addr, mem_write_data} !== e) begin
                        errors++;
                        $display("FAIL %s write: got addr 0x%02h data 0x%02h want addr 0x%02h data 0x%02h",
                                 name, mem_addr, mem_write_data, e[15:8], e[7:0]);
                    end
                end
            end
            if (hold_start) begin
                src_base   = 8'($urandom);
                dst_base   = 8'($urandom);
                length     = 8'($urandom);
                fill_value = DW'($urandom);
                fill_mode  = 1'($urandom);
            end
            if (cpu_during) cpu_mem_write = busy && (exp_q.size() != 0);
            if (done) begin
                done_cnt++;
                done_at = c;
                start = 1'b0;
                break;
            end
        end
        cpu_mem_write = 1'b0;
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s done: no done pulse within cycle budget (got %0d want 1)", name, done_cnt);
        end
        checks++;
        if (busy_cyc != exp_busy) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cyc, exp_busy);
        end
        checks++;
        if (done_at != exp_busy + 1) begin
            errors++;
            $display("FAIL %s done_latency: got %0d want %0d", name, done_at, exp_busy + 1);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_writes: got %0d left want 0", name, exp_q.size());
        end
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({done, busy, dbg_state} !== 4'b0000) begin
            errors++;
            $display("FAIL %s after_done: got done=%0b busy=%0b state=%0d want 0 0 0",
                     name, done, busy, dbg_state);
        end
        compare_mem(name);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0; fill_mode = 1'b0; src_base = '0; dst_base = '0; length = '0;
        fill_value = '0; cpu_mem_write = 1'b0; cpu_addr = '0; cpu_write_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, dbg_state} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: got busy=%0b done=%0b state=%0d want 0 0 0", busy, done, dbg_state);
        end
        cpu_mem_write = 1'b1; cpu_addr = 8'h5C; cpu_write_data = 8'h3D;
        #1;
        checks++;
        if ({mem_write, mem_addr, mem_write_data} !== {1'b1, 8'h5C, 8'h3D}) begin
            errors++;
            $display("FAIL reset_passthrough: got we=%0b addr 0x%02h data 0x%02h want 1 0x5c 0x3d",
                     mem_write, mem_addr, mem_write_data);
        end
        cpu_mem_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic init_mem();
        for (int a = 0; a < 256; a++) cpu_write(8'(a), DW'($urandom));
        compare_mem("init");
    endtask

    task automatic test_copy_basic();
        cpu_write(8'h10, 8'hA1);
        cpu_write(8'h11, 8'hB2);
        cpu_write(8'h12, 8'hC3);
        run_op(1'b0, 8'h10, 8'h40, 8'd3, 8'h00, 1'b0, 1'b0, "copy_basic");
    endtask

    task automatic test_fill_wrap();
        run_op(1'b1, 8'h00, 8'hFE, 8'd3, 8'h5A, 1'b0, 1'b0, "fill_wrap");
        checks++;
        if ({mem[8'hFE], mem[8'hFF], mem[8'h00]} !== 24'h5A5A5A) begin
            errors++;
            $display("FAIL fill_wrap words: got %02h %02h %02h want 5a 5a 5a",
                     mem[8'hFE], mem[8'hFF], mem[8'h00]);
        end
    endtask

    task automatic test_zero_length();
        run_op(1'b0, 8'h30, 8'h60, 8'd0, 8'h00, 1'b0, 1'b0, "zero_length");
        run_op(1'b1, 8'h30, 8'h60, 8'd0, 8'hFF, 1'b0, 1'b0, "zero_length_fill");
    endtask

    task automatic test_arbitration();
        cpu_addr = 8'h40; cpu_write_data = 8'hEE;
        run_op(1'b0, 8'h10, 8'h40, 8'd3, 8'h00, 1'b1, 1'b0, "arbitration");
        cpu_write(8'h40, 8'hEE);
        compare_mem("arb_after");
        @(negedge clk);
        cpu_addr = 8'h40;
        #1;
        checks++;
        if (cpu_read_data !== 8'hEE) begin
            errors++;
            $display("FAIL arb_readback: got 0x%02h want 0xee", cpu_read_data);
        end
    endtask

    task automatic test_readback();
        for (int n = 0; n < 6; n++) begin
            logic [7:0] a;
            a = 8'($urandom);
            @(negedge clk);
            cpu_addr = a;
            #1;
            checks++;
            if (cpu_read_data !== ref_mem[a]) begin
                errors++;
                $display("FAIL readback 0x%02h: got 0x%02h want 0x%02h", a, cpu_read_data, ref_mem[a]);
            end
        end
    endtask

    task automatic test_reset_mid_copy();
        int wr_cnt = 0;
        logic [15:0] e;
        model_op(1'b0, 8'h80, 8'hC0, 3, 8'h00);
        @(negedge clk);
        start = 1'b1; fill_mode = 1'b0; src_base = 8'h80; dst_base = 8'hC0; length = 8'd8;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_write) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL reset_mid write: unexpected write addr 0x%02h", mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    wr_cnt++;
                    if ({mem_addr, mem_write_data} !== e) begin
                        errors++;
                        $display("FAIL reset_mid write: got 0x%04h want 0x%04h", {mem_addr, mem_write_data}, e);
                    end
                end
            end
            if (wr_cnt == 3) break;
        end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, mem_write, dbg_state} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_mid abort: got busy=%0b done=%0b we=%0b state=%0d want 0 0 0 0 (writes=%0d)",
                     busy, done, mem_write, dbg_state, wr_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        compare_mem("reset_mid");
        run_op(1'b0, 8'h80, 8'hC0, 8'd8, 8'h00, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_overlap();
        cpu_write(8'h20, 8'h11);
        run_op(1'b0, 8'h20, 8'h21, 8'd3, 8'h00, 1'b0, 1'b0, "overlap");
        checks++;
        if ({mem[8'h21], mem[8'h22], mem[8'h23]} !== 24'h111111) begin
            errors++;
            $display("FAIL overlap words: got %02h %02h %02h want 11 11 11",
                     mem[8'h21], mem[8'h22], mem[8'h23]);
        end
    endtask

    task automatic test_start_ignored();
        run_op(1'b0, 8'h05, 8'h90, 8'd4, 8'h00, 1'b0, 1'b1, "start_held_copy");
        run_op(1'b1, 8'h00, 8'hA0, 8'd5, 8'h77, 1'b0, 1'b1, "start_held_fill");
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            run_op(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(1, 24)),
                   DW'($urandom), 1'($urandom), 1'b0, $sformatf("random%0d", n));
        end
        run_op(1'b0, 8'($urandom), 8'($urandom), 8'd1, 8'h00, 1'b0, 1'b0, "len1_copy");
        run_op(1'b1, 8'h00, 8'($urandom), 8'd255, DW'($urandom), 1'b0, 1'b0, "len255_fill");
        run_op(1'b0, 8'hF0, 8'h08, 8'd255, 8'h00, 1'b0, 1'b0, "len255_copy");
    endtask

    initial begin
        test_reset();
        init_mem();
        test_copy_basic();
        test_fill_wrap();
        test_zero_length();
        test_arbitration();
        test_readback();
        test_reset_mid_copy();
        test_overlap();
        test_start_ignored();
        test_random();
        test_readback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_block_mover.md
MEM_BLOCK_MOVER -- requirements
Module: mem_block_mover

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, the data word width, matching the data memory word width from definitions.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port fill_mode, input, 1, the mode select sampled with start: 0 = copy, 1 = fill.
REQ-006 SHALL have port src_base, input, 8, the copy source start address, sampled with start.
REQ-007 SHALL have port dst_base, input, 8, the destination start address, sampled with start.
REQ-008 SHALL have port length, input, 8, the word count, sampled with start; 0 means no transfer.
REQ-009 SHALL have port fill_value, input, D_WIDTH, the fill word, sampled with start.
REQ-010 SHALL have ports cpu_mem_write (input, 1), cpu_addr (input, 8) and cpu_write_data (input, D_WIDTH) as the processor-side memory request.
REQ-011 SHALL have port cpu_read_data, output, D_WIDTH, which equals mem_read_data at all times (combinational).
REQ-012 SHALL have ports mem_write (output, 1), mem_addr (output, 8) and mem_write_data (output, D_WIDTH), which drive the data memory write enable, address and write data.
REQ-013 SHALL have port mem_read_data, input, D_WIDTH, the data memory asynchronous read data.
REQ-014 SHALL have port busy, output, 1, high while in RD or WR.
REQ-015 SHALL have port done, output, 1, a one-cycle pulse indicating operation complete.

Function
REQ-016 SHALL implement the states IDLE, RD, WR and DONE.
REQ-017 In IDLE and DONE, SHALL pass cpu_mem_write, cpu_addr and cpu_write_data combinationally to the mem_* outputs.
REQ-018 In RD and WR, SHALL own the memory port and ignore all cpu_* inputs.
REQ-019 In IDLE with start=1, SHALL latch the operands, clear the index counter i to 0, and go next to:
  - DONE if length=0;
  - WR if fill_mode=1;
  - RD otherwise.
REQ-020 In RD, SHALL drive mem_addr=src_base+i (mod 256) with mem_write=0, capture mem_read_data into a buffer register at the clock edge, and go to WR.
REQ-021 In WR, SHALL drive mem_addr=dst_base+i (mod 256) and mem_write=1, with mem_write_data set to the buffer (copy) or fill_value (fill).
REQ-022 At the WR clock edge, SHALL increment i; if the incremented i equals length, SHALL go to DONE, otherwise to RD (copy) or stay in WR (fill).
REQ-023 SHALL take exactly 2*length busy cycles for a copy and length busy cycles for a fill; done SHALL assert on the cycle after the last write.
REQ-024 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE; start is ignored in RD, WR and DONE (no queuing).
REQ-025 SHALL wrap address arithmetic modulo 256 (e.g. src_base=0xFE with length=4 reads 0xFE, 0xFF, 0x00, 0x01).
REQ-026 SHALL perform copies strictly in ascending index order, one word at a time; overlapping regions with dst_base>src_base therefore replicate source words, and this is defined behaviour.
REQ-027 SHALL treat length as 1..255 words; length=0 completes with no memory writes.

Reset
REQ-028 On reset, SHALL asynchronously enter IDLE and clear i, the buffer and all latched operands to 0.
REQ-029 While reset is asserted, SHALL hold busy=0 and done=0; mem_* outputs follow cpu_* per IDLE passthrough.
REQ-030 Reset mid-operation SHALL abort immediately with no further writes; words already written remain in memory.

Verification
REQ-031 Copy: mem[0x10..0x12]=0xA1,0xB2,0xC3; start copy src=0x10, dst=0x40, len=3 -> 6 busy cycles, mem[0x40..0x42]=0xA1,0xB2,0xC3, one done pulse.
REQ-032 Fill with wrap: dst=0xFE, len=3, value=0x5A -> writes to 0xFE, 0xFF, 0x00 on consecutive cycles, 3 busy cycles, then done.
REQ-033 Zero length: start with len=0 -> no mem_write, busy never high, done pulses on the cycle after start.
REQ-034 Arbitration: cpu_mem_write=1 at addr 0x40 during a copy -> ignored; the same request after done writes normally, and cpu_read_data tracks memory while idle.
REQ-035 Reset mid-copy: len=8, reset after the 3rd write -> only 3 destination words changed, busy=0 immediately, and the next start works normally.
REQ-036 Overlap: mem[0x20]=0x11, copy src=0x20, dst=0x21, len=3 -> mem[0x21..0x23] all 0x11.
